// File: rtl/fq_pkg.sv
// rtl/fq_pkg.sv - shared constants for the fq_bank divider bank
// Purpose: default channel count and divisor width, plus a flag that records
//          whether the optional phase-alignment input (macro FQ_BANK_SYNC_EN)
//          is compiled in.
package fq_pkg;

    localparam int CH_DEF = 4;
    localparam int W_DEF  = 8;

`ifdef FQ_BANK_SYNC_EN
    localparam bit SYNC_EN = 1'b1;
`else
    localparam bit SYNC_EN = 1'b0;
`endif

endpackage

// File: rtl/fq_chan.sv
// rtl/fq_chan.sv - one clock-divider channel with shadowed, glitch-free divisor update
// Purpose: divides clk by 2*D using a half-period counter; a newly loaded divisor
//          is held in a shadow register and only takes effect at a half-period
//          boundary (or at once when the channel is idle).
// Optional: macro FQ_BANK_SYNC_EN adds i_sync (phase-align restart).
// Ports:
//   i_clk     rising-edge clock
//   i_rst_n   synchronous active-low reset
//   i_en      run enable (freezes counter and output when low)
//   i_load    one-cycle strobe capturing i_div
//   i_div     divisor value (0 = idle)
//   i_sync    restart strobe (FQ_BANK_SYNC_EN only)
//   o_clk     divided clock, registered
//   o_tick    pulse on each o_clk rising transition, registered
//   o_pend    shadow divisor waiting to take effect
module fq_chan
    import fq_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic         i_load,
    input  logic [W-1:0] i_div,
`ifdef FQ_BANK_SYNC_EN
    input  logic         i_sync,
`endif
    output logic         o_clk,
    output logic         o_tick,
    output logic         o_pend
);

    logic [W-1:0] r_d;
    logic [W-1:0] r_s;
    logic [W-1:0] r_cnt;
    logic         r_pend;
    logic         r_clk;
    logic         r_tick;

    logic [W-1:0] w_one;
    logic [W-1:0] w_last;
    logic [W-1:0] w_cnt_inc;
    logic [W-1:0] w_next_d;
    logic         w_idle;
    logic         w_bnd;

    assign w_one     = {{(W-1){1'b0}}, 1'b1};
    assign w_last    = r_d - w_one;
    assign w_cnt_inc = r_cnt + w_one;
    assign w_idle    = (r_d == '0);
    assign w_bnd     = !w_idle && i_en && (r_cnt == w_last);
    // A load arriving on the update edge itself wins over an older shadow value.
    assign w_next_d  = i_load ? i_div : (r_pend ? r_s : r_d);

`ifdef FQ_BANK_SYNC_EN
    logic w_sync;
    assign w_sync = i_sync && !w_idle;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_d    <= '0;
            r_s    <= '0;
            r_cnt  <= '0;
            r_pend <= 1'b0;
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
        end
`ifdef FQ_BANK_SYNC_EN
        else if (w_sync) begin
            // Restart low with a fresh count; the sync edge doubles as an update point.
            r_d    <= w_next_d;
            if (i_load) r_s <= i_div;
            r_pend <= 1'b0;
            r_cnt  <= '0;
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
        end
`endif
        else if (w_idle) begin
            r_cnt  <= '0;
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
            if (i_load) begin
                r_s    <= i_div;
                r_pend <= 1'b1;
            end else if (r_pend) begin
                // Idle channel has no boundary to wait for; apply one cycle after capture.
                r_d    <= r_s;
                r_pend <= 1'b0;
            end
        end else if (w_bnd) begin
            r_cnt  <= '0;
            r_d    <= w_next_d;
            if (i_load) r_s <= i_div;
            r_pend <= 1'b0;
            if (w_next_d == '0) begin
                // Switching to idle: force low so no rising edge escapes.
                r_clk  <= 1'b0;
                r_tick <= 1'b0;
            end else begin
                r_clk  <= ~r_clk;
                r_tick <= ~r_clk;
            end
        end else begin
            r_tick <= 1'b0;
            if (i_en) r_cnt <= w_cnt_inc;
            if (i_load) begin
                r_s    <= i_div;
                r_pend <= 1'b1;
            end
        end
    end

    assign o_clk  = r_clk;
    assign o_tick = r_tick;
    assign o_pend = r_pend;

endmodule

// File: rtl/fq_bank.sv
// rtl/fq_bank.sv - bank of CH independent programmable clock dividers
// Purpose: instantiates CH fq_chan channels sharing clk and reset.
// Optional: macro FQ_BANK_SYNC_EN adds sync_in, which restarts every
//           non-idle channel low with a zero count on the next edge.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-low reset
//   en       per-channel run enable
//   load     per-channel divisor capture strobe
//   div_in   packed divisors, channel i at [i*W +: W]
//   sync_in  phase-align strobe (FQ_BANK_SYNC_EN only)
//   clk_out  divided clocks
//   tick     rising-transition pulses
//   pending  shadow divisor waiting per channel
module fq_bank
    import fq_pkg::*;
#(
    parameter int CH = CH_DEF,
    parameter int W  = W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH-1:0]   en,
    input  logic [CH-1:0]   load,
    input  logic [CH*W-1:0] div_in,
`ifdef FQ_BANK_SYNC_EN
    input  logic            sync_in,
`endif
    output logic [CH-1:0]   clk_out,
    output logic [CH-1:0]   tick,
    output logic [CH-1:0]   pending
);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        fq_chan #(.W(W)) u_chan (
            .i_clk   (clk),
            .i_rst_n (rst),
            .i_en    (en[i]),
            .i_load  (load[i]),
            .i_div   (div_in[i*W +: W]),
`ifdef FQ_BANK_SYNC_EN
            .i_sync  (sync_in),
`endif
            .o_clk   (clk_out[i]),
            .o_tick  (tick[i]),
            .o_pend  (pending[i])
        );
    end

endmodule

// File: tb/tb_fq_bank.sv
// tb/tb_fq_bank.sv - table-driven self-checking bench for fq_bank
module tb_fq_bank;

    typedef struct {
        logic        rst;
        logic [3:0]  en;
        logic [3:0]  ld;
        logic [31:0] div;
        logic [3:0]  ck;
        logic [3:0]  tk;
        logic [3:0]  pd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  en;
    logic [3:0]  load;
    logic [31:0] div_in;
    logic [3:0]  clk_out;
    logic [3:0]  tick;
    logic [3:0]  pending;
`ifdef FQ_BANK_SYNC_EN
    logic        sync_in;
`endif

    vec_t tv[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    fq_bank #(.CH(4), .W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .load    (load),
        .div_in  (div_in),
`ifdef FQ_BANK_SYNC_EN
        .sync_in (sync_in),
`endif
        .clk_out (clk_out),
        .tick    (tick),
        .pending (pending)
    );

    task automatic add(input logic r, input logic [3:0] e, input logic [3:0] l,
                       input logic [31:0] d, input logic [3:0] c,
                       input logic [3:0] t, input logic [3:0] p);
        tv.push_back('{rst: r, en: e, ld: l, div: d, ck: c, tk: t, pd: p});
    endtask

    task automatic drive(input logic r, input logic [3:0] e, input logic [3:0] l,
                         input logic [31:0] d);
        rst    = r;
        en     = e;
        load   = l;
        div_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: clk/tick/pend got %03h required %03h", name, act, req);
    endtask

    initial begin
        rst = 1'b0; en = '0; load = '0; div_in = '0;
`ifdef FQ_BANK_SYNC_EN
        sync_in = 1'b0;
`endif
        // reset, then ch0 divisor 1: toggle every cycle, en=0 freeze
        add(0, 4'h0, 4'h0, 32'h0,        4'h0, 4'h0, 4'h0);
        add(0, 4'hF, 4'hF, 32'hFFFFFFFF, 4'h0, 4'h0, 4'h0);
        add(1, 4'h1, 4'h1, 32'h1,        4'h0, 4'h0, 4'h1);
        add(1, 4'h1, 4'h0, 32'h0,        4'h0, 4'h0, 4'h0);
        add(1, 4'h1, 4'h0, 32'h0,        4'h1, 4'h1, 4'h0);
        add(1, 4'h1, 4'h0, 32'h0,        4'h0, 4'h0, 4'h0);
        add(1, 4'h1, 4'h0, 32'h0,        4'h1, 4'h1, 4'h0);
        add(1, 4'h1, 4'h0, 32'h0,        4'h0, 4'h0, 4'h0);
        add(1, 4'h1, 4'h0, 32'h0,        4'h1, 4'h1, 4'h0);
        add(1, 4'h0, 4'h0, 32'h0,        4'h1, 4'h0, 4'h0);
        add(1, 4'h0, 4'h0, 32'h0,        4'h1, 4'h0, 4'h0);
        add(1, 4'h1, 4'h0, 32'h0,        4'h0, 4'h0, 4'h0);
        add(1, 4'h1, 4'h0, 32'h0,        4'h1, 4'h1, 4'h0);
        // ch1 D=4, load 2 mid high phase
        add(0, 4'h0, 4'h0, 32'h0,        4'h0, 4'h0, 4'h0);
        add(1, 4'h2, 4'h2, 32'h400,      4'h0, 4'h0, 4'h2);
        add(1, 4'h2, 4'h0, 32'h0,        4'h0, 4'h0, 4'h0);
        add(1, 4'h2, 4'h0, 32'h0,        4'h0, 4'h0, 4'h0);
        add(1, 4'h2, 4'h0, 32'h0,        4'h0, 4'h0, 4'h0);
        add(1, 4'h2, 4'h0, 32'h0,        4'h0, 4'h0, 4'h0);
        add(1, 4'h2, 4'h0, 32'h0,        4'h2, 4'h2, 4'h0);
        add(1, 4'h2, 4'h0, 32'h0,        4'h2, 4'h0, 4'h0);
        add(1, 4'h2, 4'h2, 32'h200,      4'h2, 4'h0, 4'h2);
        add(1, 4'h2, 4'h0, 32'h0,        4'h2, 4'h0, 4'h2);
        add(1, 4'h2, 4'h0, 32'h0,        4'h0, 4'h0, 4'h0);
        add(1, 4'h2, 4'h0, 32'h0,        4'h0, 4'h0, 4'h0);
        add(1, 4'h2, 4'h0, 32'h0,        4'h2, 4'h2, 4'h0);
        add(1, 4'h2, 4'h0, 32'h0,        4'h2, 4'h0, 4'h0);
        add(1, 4'h2, 4'h0, 32'h0,        4'h0, 4'h0, 4'h0);
        add(1, 4'h2, 4'h0, 32'h0,        4'h0, 4'h0, 4'h0);
        add(1, 4'h2, 4'h0, 32'h0,        4'h2, 4'h2, 4'h0);
        // ch2 D=3, en low for 5 cycles during high phase
        add(0, 4'h0, 4'h0, 32'h0,        4'h0, 4'h0, 4'h0);
        add(1, 4'h4, 4'h4, 32'h30000,    4'h0, 4'h0, 4'h4);
        add(1, 4'h4, 4'h0, 32'h0,        4'h0, 4'h0, 4'h0);
        add(1, 4'h4, 4'h0, 32'h0,        4'h0, 4'h0, 4'h0);
        add(1, 4'h4, 4'h0, 32'h0,        4'h0, 4'h0, 4'h0);
        add(1, 4'h4, 4'h0, 32'h0,        4'h4, 4'h4, 4'h0);
        add(1, 4'h4, 4'h0, 32'h0,        4'h4, 4'h0, 4'h0);
        for (int i = 0; i < 5; i++)
            add(1, 4'h0, 4'h0, 32'h0,    4'h4, 4'h0, 4'h0);
        add(1, 4'h4, 4'h0, 32'h0,        4'h4, 4'h0, 4'h0);
        add(1, 4'h4, 4'h0, 32'h0,        4'h0, 4'h0, 4'h0);
        add(1, 4'h4, 4'h0, 32'h0,        4'h0, 4'h0, 4'h0);
        add(1, 4'h4, 4'h0, 32'h0,        4'h0, 4'h0, 4'h0);
        add(1, 4'h4, 4'h0, 32'h0,        4'h4, 4'h4, 4'h0);
        // ch3 D=2, load 0 at a boundary where clk_out would rise
        add(0, 4'h0, 4'h0, 32'h0,        4'h0, 4'h0, 4'h0);
        add(1, 4'h8, 4'h8, 32'h02000000, 4'h0, 4'h0, 4'h8);
        add(1, 4'h8, 4'h0, 32'h0,        4'h0, 4'h0, 4'h0);
        add(1, 4'h8, 4'h0, 32'h0,        4'h0, 4'h0, 4'h0);
        add(1, 4'h8, 4'h0, 32'h0,        4'h8, 4'h8, 4'h0);
        add(1, 4'h8, 4'h0, 32'h0,        4'h8, 4'h0, 4'h0);
        add(1, 4'h8, 4'h0, 32'h0,        4'h0, 4'h0, 4'h0);
        add(1, 4'h8, 4'h0, 32'h0,        4'h0, 4'h0, 4'h0);
        add(1, 4'h8, 4'h8, 32'h0,        4'h0, 4'h0, 4'h0);
        add(1, 4'h8, 4'h0, 32'h0,        4'h0, 4'h0, 4'h0);
        add(1, 4'h8, 4'h0, 32'h0,        4'h0, 4'h0, 4'h0);
        // all channels running, mid-period reset, reload, overwrite at boundary
        add(0, 4'h0, 4'h0, 32'h0,        4'h0, 4'h0, 4'h0);
        add(1, 4'hF, 4'hF, 32'h04030201, 4'h0, 4'h0, 4'hF);
        add(1, 4'hF, 4'h0, 32'h0,        4'h0, 4'h0, 4'h0);
        add(1, 4'hF, 4'h0, 32'h0,        4'h1, 4'h1, 4'h0);
        add(1, 4'hF, 4'h0, 32'h0,        4'h2, 4'h2, 4'h0);
        add(1, 4'hF, 4'h0, 32'h0,        4'h7, 4'h5, 4'h0);
        add(1, 4'hF, 4'h0, 32'h0,        4'hC, 4'h8, 4'h0);
        add(0, 4'hF, 4'hF, 32'h05050505, 4'h0, 4'h0, 4'h0);
        add(1, 4'hF, 4'h1, 32'h2,        4'h0, 4'h0, 4'h1);
        add(1, 4'hF, 4'h0, 32'h0,        4'h0, 4'h0, 4'h0);
        add(1, 4'hF, 4'h0, 32'h0,        4'h0, 4'h0, 4'h0);
        add(1, 4'hF, 4'h0, 32'h0,        4'h1, 4'h1, 4'h0);
        add(1, 4'hF, 4'h1, 32'h5,        4'h1, 4'h0, 4'h1);
        add(1, 4'hF, 4'h1, 32'h3,        4'h0, 4'h0, 4'h0);
        add(1, 4'hF, 4'h0, 32'h0,        4'h0, 4'h0, 4'h0);
        add(1, 4'hF, 4'h0, 32'h0,        4'h0, 4'h0, 4'h0);
        add(1, 4'hF, 4'h0, 32'h0,        4'h1, 4'h1, 4'h0);

        @(negedge clk);
        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].rst, tv[i].en, tv[i].ld, tv[i].div);
            check($sformatf("row%0d", i), {clk_out, tick, pending},
                  {tv[i].ck, tv[i].tk, tv[i].pd});
        end

`ifdef FQ_BANK_SYNC_EN
        // ch0 D=3 and ch1 D=6 knocked out of phase, then aligned by sync_in
        drive(0, 4'h0, 4'h0, 32'h0);
        drive(1, 4'h3, 4'h3, 32'h0603);
        drive(1, 4'h3, 4'h0, 32'h0);
        drive(1, 4'h1, 4'h0, 32'h0);
        drive(1, 4'h1, 4'h0, 32'h0);
        drive(1, 4'h3, 4'h0, 32'h0);
        drive(1, 4'h3, 4'h0, 32'h0);
        sync_in = 1'b1;
        drive(1, 4'h3, 4'h0, 32'h0);
        sync_in = 1'b0;
        check("sync_edge", {clk_out, tick, pending}, 12'h000);
        for (int k = 1; k <= 13; k++) begin
            logic [3:0] ck;
            logic [3:0] tk;
            drive(1, 4'h3, 4'h0, 32'h0);
            ck = {2'b00, 1'(((k / 6) % 2) == 1), 1'(((k / 3) % 2) == 1)};
            tk = {2'b00, 1'((k % 12) == 6), 1'((k % 6) == 3)};
            check($sformatf("sync_k%0d", k), {clk_out, tick, pending}, {ck, tk, 4'h0});
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fq_bank.md
FQ_BANK -- requirements
Module: fq_bank

Interface
REQ-001 Parameter CH, default 4: number of independent divider channels, 1..16.
REQ-002 Parameter W, default 8: divisor width per channel, 2..16.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 en  input  CH  per-channel run enable; level-sensitive.
REQ-006 load  input  CH  per-channel one-cycle strobe that captures that channel's divisor slice.
REQ-007 div_in  input  CH*W  packed divisors; channel i uses bits [i*W +: W].
REQ-008 clk_out  output  CH  divided clock per channel, registered.
REQ-009 tick  output  CH  one-cycle pulse coincident with each clk_out rising transition, registered.
REQ-010 pending  output  CH  high while a loaded divisor waits to take effect.

Function
REQ-011 Each channel SHALL hold an active divisor D, a shadow divisor S, a half-period counter cnt (W bits) and a pending flag.
REQ-012 D=0 SHALL mean channel idle: clk_out=0, tick=0, cnt=0.
REQ-013 D>=1 and en=1: cnt counts 0..D-1; at cnt==D-1 (boundary) cnt SHALL wrap to 0 and clk_out SHALL toggle, giving period 2*D clk cycles and 50% duty.
REQ-014 D=1 SHALL produce clk_out toggling every cycle (period 2).
REQ-015 tick SHALL be 1 exactly in the cycle where clk_out registers 0->1; otherwise 0.
REQ-016 en=0 SHALL freeze cnt and clk_out at current values; tick=0; resume from frozen state on en=1.
REQ-017 load=1 SHALL capture div_in slice into S and set pending=1 on the next edge.
REQ-018 Pending S SHALL become D only at a boundary (glitch-free); pending clears the same edge.
REQ-019 If D=0 (idle), pending S SHALL become D on the cycle after capture, regardless of en.
REQ-020 load coincident with a boundary: div_in SHALL be applied directly at that boundary; pending stays 0.
REQ-021 Repeated load while pending: latest value overwrites S; only the last one applies.
REQ-022 Applying D=0 at a boundary: clk_out SHALL go to 0 (no rising edge, no tick) and channel idles.
REQ-023 Leaving idle (0 -> nonzero D): clk_out starts 0, cnt 0; first rising edge after D enabled cycles.
REQ-024 Channels SHALL be fully independent; no cross-channel interaction except sync (REQ-029).

Reset
REQ-025 rst=0 at a clock edge SHALL set D=0, S=0, cnt=0, pending=0, clk_out=0, tick=0 on all channels.
REQ-026 rst=0 SHALL override en, load and sync in the same cycle; mid-period reset truncates output without any tick.
REQ-027 First edge with rst=1 SHALL honour load normally.

Configuration
REQ-028 Macro FQ_BANK_SYNC_EN SHALL compile in a 1-bit input sync_in.
REQ-029 With FQ_BANK_SYNC_EN: sync_in=1 SHALL set cnt=0 and clk_out=0 on all non-idle channels next edge (pending divisors applied at that edge), phase-aligning all channels; tick=0 that cycle. Without it: port absent, no alignment logic.

Structure
REQ-030 Shared package fq_pkg SHALL hold default CH/W constants and the sync-macro name guard.
REQ-031 Per-channel logic SHALL live in sub-module fq_chan (parameter W), instantiated CH times by generate.

Verification
REQ-032 Reset, then W=8, load ch0 div 1, en=1 -> clk_out[0] toggles each cycle, tick every 2 cycles.
REQ-033 ch1 running D=4, load 2 mid-half-period -> pending=1 until next boundary, then period 4; no pulse shorter than 2 cycles.
REQ-034 ch2 D=3, en=0 for 5 cycles mid-high phase -> clk_out held 1, cnt frozen; resumes remaining count on en=1.
REQ-035 ch3 running D=2, load 0 at a boundary where clk_out would rise -> clk_out stays 0, no tick, idle.
REQ-036 rst=0 asserted mid-period on all channels -> all outputs 0 next edge; load on first released edge with idle channel applies next cycle.
REQ-037 FQ_BANK_SYNC_EN, ch0 D=3, ch1 D=6 out of phase, pulse sync_in -> both restart low together; coincident ticks every 6 cycles for ch0, 12 for ch1 aligned at t0.
